// File: rtl/jedro_1_arb_pkg.sv
// rtl/jedro_1_arb_pkg.sv - shared state encoding and grant bit positions for the memory arbiter
package jedro_1_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int GNT_IFU = 0;
    localparam int GNT_LSU = 1;

endpackage

// File: rtl/jedro_1_arb_timeout.sv
// rtl/jedro_1_arb_timeout.sv - per-transaction watchdog counter, expires on the last allowed wait cycle
module jedro_1_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_tie;
            assign unused_tie = ^{clk_i, rst_i, clr_i, en_i};
            assign expire_o   = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] cnt;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt <= '0;
                end else if (clr_i) begin
                    cnt <= '0;
                end else if (en_i) begin
                    cnt <= cnt + 1'b1;
                end
            end

            // Expiry is only meaningful in a cycle that is still waiting on the slave.
            assign expire_o = en_i && (cnt == CW'(TIMEOUT_CYCLES - 1));
        end
    endgenerate

endmodule

// File: rtl/jedro_1_mem_arbiter.sv
// rtl/jedro_1_mem_arbiter.sv - two-master (fetch, LSU) arbiter onto one unified RAM port
module jedro_1_mem_arbiter
    import jedro_1_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int LSU_PRIORITY   = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_stb_i,
    input  logic [DATA_WIDTH-1:0] m0_addr_i,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    input  logic                  m1_stb_i,
    input  logic [3:0]            m1_we_i,
    input  logic [DATA_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  ram_stb_o,
    output logic [3:0]            ram_we_o,
    output logic [DATA_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    input  logic                  ram_ack_i,
    input  logic                  ram_err_i,
    output logic [1:0]            grant_o,
    output logic                  busy_o
);

    localparam logic LSU_PRIO = (LSU_PRIORITY != 0);

    arb_state_t state, state_nxt;
    logic       last_grant;
    logic       busy;
    logic       resp;
    logic       tmo_expire;
    logic       fail;
    logic       pick_lsu;

    assign busy = (state == BUSY0) || (state == BUSY1);
    assign resp = ram_ack_i | ram_err_i;
    assign fail = ram_err_i | tmo_expire;

    jedro_1_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (~busy),
        .en_i    (busy & ~resp),
        .expire_o(tmo_expire)
    );

    // LSU wins when it is alone, when it has priority, or when fetch was served last.
    assign pick_lsu = m1_stb_i & (~m0_stb_i | LSU_PRIO | ~last_grant);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (m0_stb_i | m1_stb_i) begin
                    state_nxt = pick_lsu ? BUSY1 : BUSY0;
                end
            end
            BUSY0, BUSY1: begin
                if (resp | tmo_expire) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt != IDLE) begin
                last_grant <= (state_nxt == BUSY1);
            end
        end
    end

    always_comb begin
        ram_stb_o   = 1'b0;
        ram_we_o    = 4'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        m0_rdata_o  = '0;
        m0_ack_o    = 1'b0;
        m0_err_o    = 1'b0;
        m1_rdata_o  = '0;
        m1_ack_o    = 1'b0;
        m1_err_o    = 1'b0;
        grant_o     = 2'b00;
        case (state)
            BUSY0: begin
                ram_stb_o        = 1'b1;
                ram_addr_o       = m0_addr_i;
                m0_rdata_o       = ram_rdata_i;
                m0_ack_o         = ram_ack_i & ~ram_err_i;
                m0_err_o         = fail;
                grant_o[GNT_IFU] = 1'b1;
            end
            BUSY1: begin
                ram_stb_o        = 1'b1;
                ram_we_o         = m1_we_i;
                ram_addr_o       = m1_addr_i;
                ram_wdata_o      = m1_wdata_i;
                m1_rdata_o       = ram_rdata_i;
                m1_ack_o         = ram_ack_i & ~ram_err_i;
                m1_err_o         = fail;
                grant_o[GNT_LSU] = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy_o = busy;

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// tb/tb_jedro_1_mem_arbiter.sv - directed vector bench for jedro_1_mem_arbiter
module tb_jedro_1_mem_arbiter;

    typedef struct packed {
        logic        rst;
        logic        m0s;
        logic [31:0] m0a;
        logic        m1s;
        logic [3:0]  m1we;
        logic [31:0] m1a;
        logic [31:0] m1wd;
        logic [31:0] rd;
        logic        ack;
        logic        err;
    } in_t;

    typedef struct packed {
        logic        stb;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  gnt;
        logic        busy;
        logic        a0;
        logic        e0;
        logic [31:0] r0;
        logic        a1;
        logic        e1;
        logic [31:0] r1;
    } obs_t;

    typedef struct {
        in_t  i;
        obs_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_stb = 1'b0, m1_stb = 1'b0, ram_ack = 1'b0, ram_err = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0, m1_wdata = '0, ram_rdata = '0;
    logic [3:0]  m1_we = '0;
    logic [31:0] m0_rdata, m1_rdata, ram_addr, ram_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err, ram_stb, busy;
    logic [3:0]  ram_we;
    logic [1:0]  grant;

    logic        p_m0_stb = 1'b0, p_m1_stb = 1'b0;
    logic [31:0] p_m0_rdata, p_m1_rdata, p_ram_addr, p_ram_wdata;
    logic        p_m0_ack, p_m0_err, p_m1_ack, p_m1_err, p_ram_stb, p_busy;
    logic [3:0]  p_ram_we;
    logic [1:0]  p_grant;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jedro_1_mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .LSU_PRIORITY(0)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_stb_i(m0_stb), .m0_addr_i(m0_addr), .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .ram_stb_o(ram_stb), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata), .ram_ack_i(ram_ack), .ram_err_i(ram_err),
        .grant_o(grant), .busy_o(busy)
    );

    // Priority instance runs against a 1-cycle slave that acks whenever strobed.
    jedro_1_mem_arbiter #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(0), .LSU_PRIORITY(1)) dut_p (
        .clk_i(clk), .rst_i(rst),
        .m0_stb_i(p_m0_stb), .m0_addr_i(32'h0000_0A00), .m0_rdata_o(p_m0_rdata), .m0_ack_o(p_m0_ack), .m0_err_o(p_m0_err),
        .m1_stb_i(p_m1_stb), .m1_we_i(4'b0011), .m1_addr_i(32'h0000_0B00), .m1_wdata_i(32'h1111_2222),
        .m1_rdata_o(p_m1_rdata), .m1_ack_o(p_m1_ack), .m1_err_o(p_m1_err),
        .ram_stb_o(p_ram_stb), .ram_we_o(p_ram_we), .ram_addr_o(p_ram_addr), .ram_wdata_o(p_ram_wdata),
        .ram_rdata_i(32'h0BAD_F00D), .ram_ack_i(p_ram_stb), .ram_err_i(1'b0),
        .grant_o(p_grant), .busy_o(p_busy)
    );

    obs_t act;
    assign act = {ram_stb, ram_we, ram_addr, ram_wdata, grant, busy,
                  m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata};

    vec_t vecs[$];
    in_t  ci;

    task automatic set_in(input logic r, input logic m0s, input logic [31:0] m0a,
                          input logic m1s, input logic [3:0] m1we, input logic [31:0] m1a,
                          input logic [31:0] m1wd, input logic [31:0] rd,
                          input logic ack, input logic err);
        ci.rst = r;  ci.m0s = m0s; ci.m0a = m0a; ci.m1s = m1s; ci.m1we = m1we;
        ci.m1a = m1a; ci.m1wd = m1wd; ci.rd = rd; ci.ack = ack; ci.err = err;
    endtask

    task automatic push_idle();
        vec_t v;
        v.i = ci;
        v.e = '0;
        vecs.push_back(v);
    endtask

    task automatic push_busy0(input logic a, input logic e);
        vec_t v;
        v.i = ci;
        v.e = '0;
        v.e.stb = 1'b1; v.e.addr = ci.m0a; v.e.gnt = 2'b01; v.e.busy = 1'b1;
        v.e.a0 = a; v.e.e0 = e; v.e.r0 = ci.rd;
        vecs.push_back(v);
    endtask

    task automatic push_busy1(input logic a, input logic e);
        vec_t v;
        v.i = ci;
        v.e = '0;
        v.e.stb = 1'b1; v.e.we = ci.m1we; v.e.addr = ci.m1a; v.e.wdata = ci.m1wd;
        v.e.gnt = 2'b10; v.e.busy = 1'b1;
        v.e.a1 = a; v.e.e1 = e; v.e.r1 = ci.rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    initial begin
        int p_m1_grants;
        int p_m0_grants;
        int p_bad_we;
        int waited;

        // m0 read, then spurious responses in DONE/IDLE
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);                       push_idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                       push_idle();
        set_in(0, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0);                 push_idle();
        set_in(0, 1, 32'h100, 0, 0, 0, 0, 32'hDEAD_BEEF, 1, 0);     push_busy0(1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 32'h1234, 1, 1);                push_idle();
        set_in(0, 0, 0, 0, 0, 0, 0, 32'h1234, 1, 0);                push_idle();
        // round-robin with both masters always requesting
        set_in(1, 1, 32'h200, 1, 4'b0011, 32'h300, 32'hCAFE_0001, 0, 0, 0); push_idle();
        set_in(0, 1, 32'h200, 1, 4'b0011, 32'h300, 32'hCAFE_0001, 0, 0, 0); push_idle();
        for (int t = 0; t < 4; t++) begin
            set_in(0, 1, 32'h200, 1, 4'b0011, 32'h300, 32'hCAFE_0001, 32'hA000_0000 + t, 1, 0);
            if (t % 2 == 0) push_busy0(1, 0); else push_busy1(1, 0);
            set_in(0, 1, 32'h200, 1, 4'b0011, 32'h300, 32'hCAFE_0001, 0, 0, 0);
            push_idle();
            if (t != 3) push_idle();
        end
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                       push_idle();
        // m1 write with err+ack together; m0 request arriving mid-transaction must wait
        set_in(0, 0, 0, 1, 4'hF, 32'h400, 32'h5555_AAAA, 0, 0, 0);  push_idle();
        set_in(0, 1, 32'h500, 1, 4'hF, 32'h400, 32'h5555_AAAA, 32'h77, 1, 1); push_busy1(0, 1);
        set_in(0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0);                 push_idle();
        push_idle();
        // timeout: slave silent, error in the 4th busy cycle
        push_busy0(0, 0); push_busy0(0, 0); push_busy0(0, 0); push_busy0(0, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                       push_idle();
        push_idle();
        // ack arriving on the expiry cycle is a normal completion
        set_in(0, 1, 32'h600, 0, 0, 0, 0, 0, 0, 0);                 push_idle();
        push_busy0(0, 0); push_busy0(0, 0); push_busy0(0, 0);
        set_in(0, 1, 32'h600, 0, 0, 0, 0, 32'h9, 1, 0);             push_busy0(1, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                       push_idle();

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            rst = vecs[k].i.rst; m0_stb = vecs[k].i.m0s; m0_addr = vecs[k].i.m0a;
            m1_stb = vecs[k].i.m1s; m1_we = vecs[k].i.m1we; m1_addr = vecs[k].i.m1a;
            m1_wdata = vecs[k].i.m1wd; ram_rdata = vecs[k].i.rd;
            ram_ack = vecs[k].i.ack; ram_err = vecs[k].i.err;
            #1;
            total++;
            if (act !== vecs[k].e) begin
                bad++;
                $display("FAIL vec%0d: got %h want %h", k, act, vecs[k].e);
            end
        end

        // asynchronous reset in the middle of an LSU transaction
        @(negedge clk);
        m0_stb = 1'b0; m1_stb = 1'b1; m1_addr = 32'h700; m1_we = 4'h1; ram_ack = 1'b0;
        #1 chk("async_pre_idle_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        #1 chk("async_pre_grant", {30'b0, grant}, 32'd2);
        ram_ack = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async_stb", {31'b0, ram_stb}, 32'd0);
        chk("async_grant", {30'b0, grant}, 32'd0);
        chk("async_busy", {31'b0, busy}, 32'd0);
        chk("async_no_resp", {28'b0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0; ram_ack = 1'b0; m0_stb = 1'b1; m1_stb = 1'b1; m0_addr = 32'h800;
        #1 chk("post_rst_idle", {30'b0, grant}, 32'd0);
        @(negedge clk);
        #1 chk("post_rst_first_tie", {30'b0, grant}, 32'd1);
        @(negedge clk);
        m0_stb = 1'b0; m1_stb = 1'b0;

        // fixed LSU priority: m0 starves while m1 keeps requesting
        p_m1_grants = 0; p_m0_grants = 0; p_bad_we = 0;
        @(negedge clk);
        p_m0_stb = 1'b1; p_m1_stb = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (p_grant == 2'b10) p_m1_grants++;
            if (p_grant == 2'b01) p_m0_grants++;
            if (p_grant == 2'b10 && p_ram_we !== 4'b0011) p_bad_we++;
            @(negedge clk);
        end
        chk("prio_m1_grants", p_m1_grants, 32'd4);
        chk("prio_m0_grants", p_m0_grants, 32'd0);
        chk("prio_we_passthru", p_bad_we, 32'd0);
        p_m1_stb = 1'b0;
        waited = 0;
        #1;
        while (p_grant !== 2'b01 && waited < 6) begin
            @(negedge clk);
            #1;
            waited++;
        end
        chk("prio_m0_after_m1_drops", {30'b0, p_grant}, 32'd1);
        chk("prio_m0_rdata", p_m0_rdata, 32'h0BAD_F00D);
        chk("prio_m0_ack", {31'b0, p_m0_ack}, 32'd1);
        p_m0_stb = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
